// File: rtl/bus_arb_mux_if.sv
// bus_arb_mux_if: groups the select/arbitration inputs, source data and
// registered bus outputs of bus_arb_mux.
//   master modport : the side that drives selects, requests and source data
//                    and observes the registered bus (control unit / bench)
//   slave modport  : bus_arb_mux itself
// Handshake semantics: there is no backpressure. A source is transferred
// in every cycle in which a select or request wins. bus_valid is high for
// exactly the cycles whose bus_out was freshly loaded.
interface bus_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 24,
  parameter int CNT_W = 16
);
  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic                   mode;
  logic [N_SRC-1:0]       sel_onehot;
  logic [N_SRC-1:0]       req;
  logic                   lock;
  logic [N_SRC*WIDTH-1:0] data_in;
  logic                   err_clear;
  logic                   cnt_clear;
  logic [WIDTH-1:0]       bus_out;
  logic                   bus_valid;
  logic [SEL_W-1:0]       sel_index;
  logic [N_SRC-1:0]       grant;
  logic                   multi_hot_err;
  logic [CNT_W-1:0]       xfer_count;

  modport master (
    output mode, sel_onehot, req, lock, data_in, err_clear, cnt_clear,
    input  bus_out, bus_valid, sel_index, grant, multi_hot_err, xfer_count
  );

  modport slave (
    input  mode, sel_onehot, req, lock, data_in, err_clear, cnt_clear,
    output bus_out, bus_valid, sel_index, grant, multi_hot_err, xfer_count
  );
endinterface

// File: rtl/bus_arb_mux.sv
// bus_arb_mux: registered N_SRC-to-1 bus multiplexer.
// Source chosen each cycle either by a one-hot direct select (mode = 0,
// lowest set bit wins, multi-hot flagged) or by round-robin arbitration
// with bus locking (mode = 1). All outputs are registered; latency is one
// cycle, throughput one transfer per cycle.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : bus_arb_mux_if.slave (selects, requests, data, outputs)
module bus_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 24,
  parameter int CNT_W = 16
) (
  input logic          clock,
  input logic          reset_n,
  bus_arb_mux_if.slave bus
);
  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [WIDTH-1:0] bus_q, bus_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             own_vld_q, own_vld_d;
  logic [SEL_W-1:0] own_q, own_d;

  logic             dir_hit, arb_hit, win_hit, lock_hold, multi_hot;
  logic [SEL_W-1:0] dir_idx, arb_idx, win_idx;
  int               j;

  always_comb begin
    // Direct select: scanning downward leaves the lowest set bit as winner.
    dir_hit = 1'b0;
    dir_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (bus.sel_onehot[i]) begin
        dir_hit = 1'b1;
        dir_idx = SEL_W'(i);
      end
    end
    multi_hot = (bus.sel_onehot & (bus.sel_onehot - N_SRC'(1))) != '0;

    // Round-robin: first request at or above the pointer, wrapping.
    arb_hit = 1'b0;
    arb_idx = '0;
    j       = 0;
    for (int k = 0; k < N_SRC; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_SRC) j = j - N_SRC;
      if (!arb_hit && bus.req[j]) begin
        arb_hit = 1'b1;
        arb_idx = SEL_W'(j);
      end
    end

    // The owner is the previous arbitration winner; it is only tracked
    // while in arbitration mode, so a mode switch drops ownership.
    lock_hold = bus.lock && own_vld_q && bus.req[own_q];

    if (bus.mode) begin
      win_hit = lock_hold ? 1'b1  : arb_hit;
      win_idx = lock_hold ? own_q : arb_idx;
    end else begin
      win_hit = dir_hit;
      win_idx = dir_idx;
    end

    bus_d   = win_hit ? bus.data_in[int'(win_idx)*WIDTH +: WIDTH] : bus_q;
    idx_d   = win_hit ? win_idx : idx_q;
    valid_d = win_hit;
    grant_d = win_hit ? (N_SRC'(1) << win_idx) : '0;

    ptr_d = ptr_q;
    if (bus.mode && win_hit && !lock_hold) begin
      ptr_d = (win_idx == SEL_W'(N_SRC - 1)) ? '0 : win_idx + SEL_W'(1);
    end

    own_vld_d = bus.mode && win_hit;
    own_d     = win_hit ? win_idx : own_q;

    // Set has priority over clear.
    err_d = (!bus.mode && multi_hot) || (err_q && !bus.err_clear);

    // Counts the registered bus_valid, hence one extra cycle of lag.
    if (bus.cnt_clear)                 cnt_d = '0;
    else if (valid_q && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
    else                               cnt_d = cnt_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_q     <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      grant_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      own_vld_q <= 1'b0;
      own_q     <= '0;
    end else begin
      bus_q     <= bus_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      own_vld_q <= own_vld_d;
      own_q     <= own_d;
    end
  end

  assign bus.bus_out       = bus_q;
  assign bus.bus_valid     = valid_q;
  assign bus.sel_index     = idx_q;
  assign bus.grant         = grant_q;
  assign bus.multi_hot_err = err_q;
  assign bus.xfer_count    = cnt_q;
endmodule

// File: doc/bus_arb_mux.md
# bus_arb_mux

Parametrised, registered successor to the datapath bus multiplexer and encoder. It drives one WIDTH-bit bus from N_SRC sources. Each cycle the source comes from a one-hot direct select (control-unit style) or from round-robin arbitration with bus locking. A one-cycle output register, multi-hot error detection and a saturating transfer counter are included. It sits between the register file, special registers and I/O on one side and every bus consumer on the other.

## Interface
- WIDTH, 32, bus and source data width
- N_SRC, 24, number of sources (2..32); SEL_W = clog2(N_SRC) is derived internally
- CNT_W, 16, width of the transfer counter
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = direct one-hot select, 1 = round-robin arbitration
- sel_onehot  in  N_SRC  direct-mode select, bit i selects source i
- req  in  N_SRC  arbitration-mode requests
- lock  in  1  arbitration mode: keep the current grant while its request stays high
- data_in  in  N_SRC*WIDTH  flattened sources, source i at [i*WIDTH +: WIDTH]
- err_clear  in  1  clears multi_hot_err
- cnt_clear  in  1  clears xfer_count
- bus_out  out  WIDTH  registered bus value
- bus_valid  out  1  bus_out was loaded from a selected source this cycle
- sel_index  out  SEL_W  registered index of the source driving bus_out
- grant  out  N_SRC  registered one-hot grant; zero when idle
- multi_hot_err  out  1  sticky; set when more than one sel_onehot bit was high in direct mode
- xfer_count  out  CNT_W  saturating count of cycles with bus_valid = 1

## Operation
- Reset (asynchronous, reset_n = 0):
  - bus_out, sel_index, grant, xfer_count = 0
  - bus_valid, multi_hot_err = 0
  - round-robin pointer = 0; lock ownership is cleared.
- Selection is combinational from the current inputs. All outputs are registered.
- Direct mode (mode = 0):
  - Exactly one sel_onehot bit i high: load data_in[i] into bus_out, sel_index = i, grant = 1<<i, bus_valid = 1.
  - No bit high: bus_out and sel_index hold their values, grant = 0, bus_valid = 0.
  - More than one bit high: the lowest set index wins and is loaded as above, and multi_hot_err is set.
  - req and lock are ignored in direct mode.
- Arbitration mode (mode = 1):
  - The winner is the first req bit at or above the pointer, searching upward and wrapping from N_SRC-1 to 0.
  - On a grant to index g, the pointer becomes (g+1) mod N_SRC.
  - Loading of bus_out, sel_index, grant and bus_valid follows the same rules as direct mode.
  - lock = 1 with a current owner o and req[o] = 1: o is re-granted, and the pointer does not advance.
  - Lock ends when req[o] falls or lock falls. Normal arbitration resumes in that same cycle.
  - No requests: grant = 0, bus_valid = 0, bus_out holds, pointer holds.
  - sel_onehot is ignored, so multi_hot_err cannot be set in arbitration mode.
- Mode switch:
  - The new mode applies to the selection in the first cycle in which mode carries the new value.
  - Lock ownership is cleared on the switch. The pointer is preserved.
- multi_hot_err:
  - Set in a cycle with a direct-mode multi-hot select.
  - Cleared by err_clear. If set and clear occur in the same cycle, set wins.
- xfer_count:
  - Increments by 1 for each registered bus_valid = 1 cycle.
  - Saturates at 2^CNT_W - 1.
  - cnt_clear resets it to 0, and clear wins over an increment in the same cycle.

## Timing
- Latency is one cycle. Inputs sampled at edge t appear on bus_out, bus_valid, sel_index and grant after edge t.
- xfer_count reflects bus_valid with one further cycle of lag.
- Throughput is one transfer per cycle. Back-to-back grants to different sources carry no bubble.
- A grant decision uses only the registered pointer and owner state, so there are no combinational loops.
- Reset asserted mid-transfer clears all state immediately. The first valid output after reset_n rises appears one edge after a valid select.
- Every output is glitch-free and changes only on the clock edge or on reset.

## Test plan
- Direct select:
  - Stimulus: data_in[0] = 0xAAAAAAAA, sel_onehot = 0x000001, then source 1 = 0xBBBBBBBB with 0x000002, then source 23 = 0xCCCCCCCC with 0x800000.
  - Required response: bus_out follows one cycle later, sel_index = 0, 1, 23, and bus_valid = 1 each time.
- Idle hold and multi-hot:
  - Stimulus: sel_onehot = 0 after a 0xBBBBBBBB transfer, then sel_onehot = 0x000006.
  - Required response: idle cycle shows bus_out = 0xBBBBBBBB, bus_valid = 0, grant = 0. Multi-hot cycle shows sel_index = 1 and multi_hot_err = 1, which stays set until err_clear.
- Round-robin:
  - Stimulus: mode = 1, req = 0x000009 held.
  - Required response: grants alternate 0, 3, 0, 3.
  - Stimulus: req = 0x800001 with pointer at 23.
  - Required response: grant 23, then 0 (wrap).
- Lock:
  - Stimulus: req = 0x000006 with lock = 1 after a grant to 1.
  - Required response: grant stays 1. After req[1] drops, the next grant is 2 in that cycle's result.
- Counter and reset:
  - Stimulus: CNT_W = 4, 20 valid cycles.
  - Required response: xfer_count saturates at 15. cnt_clear gives 0.
  - Stimulus: reset_n pulsed low mid-stream.
  - Required response: all outputs return to 0 asynchronously.
